booth_multiplier_16bit: RTL and testbench
=========================================

// Module: booth_multiplier_16bit
// PURPOSE
//  Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH product, one Booth step per clock.
//  Inverse-operation partner of the non-restoring divider in the arithmetic unit; same
//  start/done style so both can share one operand/result datapath.
// PARAMETERS
//  WIDTH     16   operand width in bits (two's complement); product is 2*WIDTH bits
// PORTS
//  clk           in   1        rising-edge clock
//  rst_n         in   1        asynchronous active-low reset
//  start         in   1        request; sampled only in IDLE
//  multiplicand  in   WIDTH    signed operand M, captured on accepted start
//  multiplier    in   WIDTH    signed operand Q, captured on accepted start
//  product       out  2*WIDTH  signed result, held stable from DONE until next accepted start
//  busy          out  1        high in RUN and DONE
//  done          out  1        one-cycle pulse, product valid
// BEHAVIOUR
//  Clock clk; reset rst_n asynchronous, active-low.
//  Reset: state=IDLE, product=0, busy=0, done=0, count=0, internal regs=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 at edge E0 -> A=0 (WIDTH+1 bits), Qr=multiplier, q_m1=0, Mr=sext(multiplicand), count=0, go RUN.
//   RUN: each edge E1..E_WIDTH, on pair {Qr[0],q_m1}: 01 -> A=A+Mr; 10 -> A=A-Mr; 00/11 -> A unchanged;
//        then arithmetic shift right of {A,Qr,q_m1} by 1 (A MSB replicated); count++.
//        At E_WIDTH (count==WIDTH-1 before increment): product <= {A[WIDTH-1:0],Qr} of shifted value, go DONE.
//   DONE: done=1, busy=1 for exactly one cycle; next edge -> IDLE, done=0.
//  Latency: done high in cycle after E_WIDTH, i.e. WIDTH+1 edges after start sampled; throughput one op per WIDTH+2 cycles.
//  Width rules: A is WIDTH+1 bits so A-Mr with Mr=-2^(WIDTH-1) never overflows; result exact for all
//   operand pairs incl. (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2); no saturation, no overflow flag.
//  start while busy (RUN or DONE): ignored, no queuing; operand inputs ignored outside accepted start.
//  start held high continuously: new op accepted on first IDLE edge after DONE.
//  product updates only at E_WIDTH; holds old value during RUN.
//  Reset mid-operation: immediate abort, all outputs to reset values, no done pulse.
//  count width = $clog2(WIDTH)+1.
// STRUCTURE
//  Shared package arith_pkg: FSM state localparams (ST_IDLE, ST_RUN, ST_DONE, 2-bit encoding), default
//   WIDTH constant, shared with the divider for common control.
//  One sub-module: booth_step (combinational) — inputs A, Qr, q_m1, Mr; outputs next A, Qr, q_m1 after
//   add/sub and arithmetic shift. Top holds FSM, counter, operand/result registers.
// TESTING
//  3 x 5 -> done 17 cycles after start, product=0x0000000F, busy high 17 cycles.
//  -7 (0xFFF9) x 6 -> product=0xFFFFFFD6 (-42); 32767 x -1 -> 0xFFFF8001.
//  -32768 x -32768 (0x8000,0x8000) -> product=0x40000000; -32768 x 1 -> 0xFFFF8000.
//  0 x 0x1234 -> 0x00000000; product from previous op holds until E_WIDTH of next op.
//  start pulsed with 2x2 mid-RUN of 4x4 -> result 0x00000010 only, one done pulse, second start ignored.
//  rst_n low at count=8 of 9x9 -> product=0, busy=0, done=0 at once; fresh 9x9 after release -> 0x00000051.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: control-state encoding and default operand width.
// Latency: none (declarations only).
// Backpressure: none; the multiplier and divider use the same start/busy/done handshake.
package arith_pkg;

  // Default operand width for the multiplier/divider pair.
  localparam int DEF_WIDTH = 16;

  // Common control states. The 2-bit encoding lets the divider use the same state register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract Mr by the {Qr[0],q_m1} pair, then arithmetic shift right.
// Latency: combinational.
// Backpressure: none; the owning FSM decides when to register the result.
module booth_step
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] qr,
  input  logic             q_m1,
  input  logic [WIDTH:0]   mr,
  output logic [WIDTH:0]   a_nx,
  output logic [WIDTH-1:0] qr_nx,
  output logic             q_m1_nx
);

  logic [WIDTH:0] sum;

  // Recode the bit pair, then shift {sum,qr,q_m1} right by one, replicating the sign of sum.
  always_comb begin
    sum = a;
    case ({qr[0], q_m1})
      2'b01:   sum = a + mr;
      2'b10:   sum = a - mr;
      default: sum = a;
    endcase
    a_nx    = {sum[WIDTH], sum[WIDTH:1]};
    qr_nx   = {sum[0], qr[WIDTH-1:1]};
    q_m1_nx = qr[0];
  end

endmodule

// File: rtl/booth_multiplier_16bit.sv
// Sequential signed radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, one step per clock.
// Latency: done pulses WIDTH+1 edges after start is accepted; one op per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module booth_multiplier_16bit
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  // A carries one extra bit so A - Mr cannot overflow when Mr is the most negative value.
  logic [WIDTH:0]   a_q, mr_q, a_nx;
  logic [WIDTH-1:0] qr_q, qr_nx;
  logic             q_m1_q, q_m1_nx;
  logic [CW-1:0]    count;
  logic             last_step;

  assign last_step = (state == ST_RUN) && (count == LAST);

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a       (a_q),
    .qr      (qr_q),
    .q_m1    (q_m1_q),
    .mr      (mr_q),
    .a_nx    (a_nx),
    .qr_nx   (qr_nx),
    .q_m1_nx (q_m1_nx)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state and status outputs decoded from the current state.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last_step) state_nx = ST_DONE;
      end
      ST_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand capture on accepted start, one Booth step per RUN cycle, result latched on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      mr_q    <= '0;
      qr_q    <= '0;
      q_m1_q  <= 1'b0;
      count   <= '0;
      product <= '0;
    end else if (state == ST_IDLE && start) begin
      a_q    <= '0;
      mr_q   <= {multiplicand[WIDTH-1], multiplicand};
      qr_q   <= multiplier;
      q_m1_q <= 1'b0;
      count  <= '0;
    end else if (state == ST_RUN) begin
      a_q    <= a_nx;
      qr_q   <= qr_nx;
      q_m1_q <= q_m1_nx;
      count  <= count + CW'(1);
      if (last_step) product <= {a_nx[WIDTH-1:0], qr_nx};
    end
  end

endmodule

// File: tb/tb_booth_multiplier_16bit.sv
module tb_booth_multiplier_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] multiplicand = '0;
  logic [15:0] multiplier = '0;
  logic [31:0] product;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_prod = '0;

  booth_multiplier_16bit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] m;
    logic [15:0] q;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Reference: plain signed integer multiplication, truncated to the 32-bit product.
  function automatic logic [31:0] ref_mul(input logic [15:0] m, input logic [15:0] q);
    longint sm, sq, p;
    sm = longint'($signed(m));
    sq = longint'($signed(q));
    p  = sm * sq;
    return p[31:0];
  endfunction

  // Issue one op from idle; check product, latency, busy length, and that product held until done.
  task automatic run_op(input string nm, input logic [15:0] m, input logic [15:0] q,
                        input logic [31:0] exp);
    int   edges = 0;
    int   bc = 0;
    logic seen = 1'b0;
    logic held = 1'b1;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    while (!seen && edges < 40) begin
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
      if (busy) bc++;
      if (done) seen = 1'b1;
      else if (product !== last_prod) held = 1'b0;
    end
    chk({nm, " seen_done"}, 64'(seen), 64'd1);
    chk({nm, " product"}, 64'(product), 64'(exp));
    chk({nm, " latency"}, 64'(edges), 64'd17);
    chk({nm, " busy_cycles"}, 64'(bc), 64'd17);
    chk({nm, " held_old"}, 64'(held), 64'd1);
    last_prod = exp;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{16'd3,    16'd5,    32'h0000000F};
    tbl[1] = '{16'hFFF9, 16'd6,    32'hFFFFFFD6};
    tbl[2] = '{16'h7FFF, 16'hFFFF, 32'hFFFF8001};
    tbl[3] = '{16'h8000, 16'h8000, 32'h40000000};
    tbl[4] = '{16'h8000, 16'd1,    32'hFFFF8000};
    tbl[5] = '{16'd0,    16'h1234, 32'h00000000};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    tbl[7] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};

    // Reset state
    #12;
    chk("reset product", 64'(product), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), tbl[i].m, tbl[i].q, tbl[i].exp);

    // Start pulsed mid-RUN is ignored: only 4x4 completes, exactly one done pulse.
    begin
      int   dones = 0;
      logic [31:0] got = '0;
      multiplicand = 16'd4; multiplier = 16'd4; start = 1'b1;
      for (int e = 1; e <= 40; e++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (e == 5) begin
          start = 1'b1; multiplicand = 16'd2; multiplier = 16'd2;
        end
        if (done) begin
          dones++;
          got = product;
        end
      end
      start = 1'b0;
      chk("midrun product", 64'(got), 64'h10);
      chk("midrun done_count", 64'(dones), 64'd1);
      last_prod = 32'h10;
    end

    // Start held high: back-to-back ops WIDTH+2 cycles apart; operands only captured on accept.
    begin
      int d1 = 0, d2 = 0;
      logic [31:0] p1 = '0, p2 = '0;
      multiplicand = 16'd3; multiplier = 16'd5; start = 1'b1;
      for (int e = 1; e <= 60 && d2 == 0; e++) begin
        @(posedge clk); #1;
        if (e == 1) begin
          multiplicand = 16'd6; multiplier = 16'd7;
        end
        if (done) begin
          if (d1 == 0) begin d1 = e; p1 = product; end
          else begin d2 = e; p2 = product; end
        end
      end
      start = 1'b0;
      chk("held first product", 64'(p1), 64'hF);
      chk("held second product", 64'(p2), 64'd42);
      chk("held first latency", 64'(d1), 64'd17);
      chk("held spacing", 64'(d2 - d1), 64'd18);
      last_prod = 32'd42;
      @(posedge clk); #1;
    end

    // Reset mid-operation at count 8 of 9x9, then a fresh 9x9.
    begin
      int stray = 0;
      multiplicand = 16'd9; multiplier = 16'd9; start = 1'b1;
      for (int e = 1; e <= 9; e++) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("abort product", 64'(product), 64'd0);
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort done", 64'(done), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int e = 0; e < 4; e++) begin
        @(posedge clk); #1;
        if (done || busy) stray++;
      end
      chk("abort no_activity", 64'(stray), 64'd0);
      last_prod = '0;
      run_op("after_abort", 16'd9, 16'd9, 32'h51);
    end

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] m, q;
      m = 16'($urandom);
      q = 16'($urandom);
      if (i % 10 == 0) m = 16'h8000;
      if (i % 10 == 5) q = 16'h8000;
      run_op($sformatf("rand%0d", i), m, q, ref_mul(m, q));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
